multicycle_ctrl: RTL and testbench

Parametrised multi-cycle sequencer for the CPU core, replacing single-cycle control. It steps each instruction through BOOT/FETCH/DECODE/EXEC/MEM/WB over one shared instruction/data memory port with a req/ready handshake, so memory may insert wait states. It owns the PC, instruction register, ALU result register and memory data register. It consumes decoder control bits and ALU results; it drives register-file write-back.

---
 rtl/multicycle_ctrl_if.sv | 13 +
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared instruction/data memory port with a req/ready handshake
//   master drives req, we (1 = store), addr and wdata
//   slave drives ready (access completes this cycle) and rdata (valid with ready)
interface multicycle_ctrl_if #(parameter int XLEN = 32);
  logic req;
  logic we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic ready;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, input ready, rdata);
  modport slave(input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: BOOT/FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port
//   clk, reset (async, active-low); mem: memory port (master side)
//   dec_*, imm, rs2_data, alu_out, alu_zero: decoder, register-file and ALU inputs
//   pc, ir, rf_we, rd_data, state: sequencer state and write-back outputs
//   CTRL_PERF_EN adds cycle_cnt and instret counters
module multicycle_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP = XLEN'(4)
) (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.master mem,
  input  logic dec_branch,
  input  logic dec_memread,
  input  logic dec_memwrite,
  input  logic dec_regwrite,
  input  logic dec_memtoreg,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_out,
  input  logic alu_zero,
  output logic [XLEN-1:0] pc,
  output logic [31:0] ir,
  output logic rf_we,
  output logic [XLEN-1:0] rd_data,
  output logic [2:0] state
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);
  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, mdr_q, mdr_d, pc_seq;
  logic [31:0] ir_q, ir_d;

  assign pc_seq = pc_q + PC_STEP;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    alu_d = alu_q;
    mdr_d = mdr_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        ir_d = mem.ready ? mem.rdata[31:0] : ir_q;
        state_d = mem.ready ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        alu_d = alu_out;
        // branch outranks the memory and write-back controls
        if (dec_branch) begin
          pc_d = alu_zero ? pc_q + imm : pc_seq;
          state_d = FETCH;
        end else if (dec_memread | dec_memwrite) begin
          state_d = MEM;
        end else if (dec_regwrite) begin
          state_d = WB;
        end else begin
          pc_d = pc_seq;
          state_d = FETCH;
        end
      end
      MEM: begin
        // memwrite wins when both memory controls are set
        if (mem.ready && dec_memwrite) begin
          pc_d = pc_seq;
          state_d = FETCH;
        end else if (mem.ready) begin
          mdr_d = mem.rdata;
          state_d = WB;
        end
      end
      WB: begin
        pc_d = pc_seq;
        state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      ir_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
    end
  end

  // outputs decode from state only, so reset silences them without a clock edge
  assign mem.req = state_q == FETCH || state_q == MEM;
  assign mem.we = state_q == MEM && dec_memwrite;
  assign mem.addr = state_q == FETCH ? pc_q : state_q == MEM ? alu_q : '0;
  assign mem.wdata = state_q == MEM ? rs2_data : '0;
  assign rf_we = state_q == WB && dec_regwrite;
  assign rd_data = state_q == WB ? (dec_memtoreg ? mdr_q : alu_q) : '0;
  assign pc = pc_q;
  assign ir = ir_q;
  assign state = state_q;

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_q, instret_d;

  always_comb begin
    cycle_cnt_d = state_q != BOOT ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    // retire on every return to FETCH from a completing state
    instret_d = state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB) ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instret_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instret = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed table plus randomized instructions against a per-instruction trace model
module tb_multicycle_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk;
  logic reset;
  logic dec_branch, dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg;
  logic [31:0] imm, rs2_data, alu_out;
  logic alu_zero;
  logic [31:0] pc, ir, rd_data;
  logic rf_we;
  logic [2:0] state;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret;
`endif

  multicycle_ctrl_if #(.XLEN(32)) bus();

  multicycle_ctrl #(.XLEN(32), .RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk),
    .reset(reset),
    .mem(bus),
    .dec_branch(dec_branch),
    .dec_memread(dec_memread),
    .dec_memwrite(dec_memwrite),
    .dec_regwrite(dec_regwrite),
    .dec_memtoreg(dec_memtoreg),
    .imm(imm),
    .rs2_data(rs2_data),
    .alu_out(alu_out),
    .alu_zero(alu_zero),
    .pc(pc),
    .ir(ir),
    .rf_we(rf_we),
    .rd_data(rd_data),
    .state(state)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instret(instret)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic req;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic rfwe;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] ir;
  } obs_t;

  typedef struct {
    obs_t e;
    logic rdy;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic zero;
  } step_t;

  // c = {branch, memread, memwrite, regwrite, memtoreg}
  typedef struct {
    logic [4:0] c;
    logic [31:0] instr, alu, imm, rs2, rdata;
    logic zero;
    int fw, mwt;
    logic [31:0] epc;
    logic erf;
    logic [31:0] erd;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mpc, mir, malu, mmdr, mcyc, minst;
  step_t q[$];
  vec_t tbl[15];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void push(logic [2:0] st, logic req, logic we, logic [31:0] addr, logic [31:0] wdata,
                               logic rfwe, logic [31:0] rd, logic rdy, logic [31:0] rdata, logic [31:0] alu, logic zero);
    step_t s;
    s.e = '{st, req, we, addr, wdata, rfwe, rd, mpc, mir};
    s.rdy = rdy;
    s.rdata = rdata;
    s.alu = alu;
    s.zero = zero;
    q.push_back(s);
  endfunction

  function automatic obs_t sample(input obs_t e);
    obs_t g;
    g.st = state;
    g.req = bus.req;
    g.we = bus.we;
    g.addr = e.req ? bus.addr : '0;
    g.wdata = e.st == 3'd4 ? bus.wdata : '0;
    g.rfwe = rf_we;
    g.rd = rd_data;
    g.pc = pc;
    g.ir = ir;
    return g;
  endfunction

  function automatic vec_t mk(logic [4:0] c, logic [31:0] instr, logic [31:0] alu, logic [31:0] imm_v,
                              logic [31:0] rs2, logic [31:0] rdata, logic zero, int fw, int mwt,
                              logic [31:0] epc, logic erf, logic [31:0] erd);
    vec_t v;
    v.c = c; v.instr = instr; v.alu = alu; v.imm = imm_v; v.rs2 = rs2; v.rdata = rdata;
    v.zero = zero; v.fw = fw; v.mwt = mwt; v.epc = epc; v.erf = erf; v.erd = erd;
    return v;
  endfunction

  // Expected per-cycle behaviour of one instruction, straight from the state rules
  task automatic run_instr(input vec_t v, input int stop_at, output logic seen, output logic [31:0] rdv);
    logic [31:0] npc;
    obs_t g;
    q.delete();
    seen = 1'b0;
    rdv = '0;
    for (int i = 0; i < v.fw; i++) push(3'd1, 1'b1, 1'b0, mpc, '0, 1'b0, '0, 1'b0, $urandom, $urandom, 1'($urandom));
    push(3'd1, 1'b1, 1'b0, mpc, '0, 1'b0, '0, 1'b1, v.instr, $urandom, 1'($urandom));
    mir = v.instr;
    push(3'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'($urandom), $urandom, $urandom, 1'($urandom));
    push(3'd3, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'($urandom), $urandom, v.alu, v.zero);
    malu = v.alu;
    npc = mpc + 32'd4;
    if (v.c[4]) begin
      npc = v.zero ? mpc + v.imm : mpc + 32'd4;
    end else if (v.c[3] | v.c[2]) begin
      for (int i = 0; i < v.mwt; i++) push(3'd4, 1'b1, v.c[2], malu, v.rs2, 1'b0, '0, 1'b0, $urandom, $urandom, 1'($urandom));
      push(3'd4, 1'b1, v.c[2], malu, v.rs2, 1'b0, '0, 1'b1, v.rdata, $urandom, 1'($urandom));
      if (!v.c[2]) begin
        mmdr = v.rdata;
        push(3'd5, 1'b0, 1'b0, '0, '0, v.c[1], v.c[0] ? mmdr : malu, 1'($urandom), $urandom, $urandom, 1'($urandom));
      end
    end else if (v.c[1]) begin
      push(3'd5, 1'b0, 1'b0, '0, '0, 1'b1, v.c[0] ? mmdr : malu, 1'($urandom), $urandom, $urandom, 1'($urandom));
    end
    for (int k = 0; k < q.size() && (stop_at < 0 || k < stop_at); k++) begin
      @(negedge clk);
      {dec_branch, dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg} = v.c;
      imm = v.imm;
      rs2_data = v.rs2;
      bus.ready = q[k].rdy;
      bus.rdata = q[k].rdata;
      alu_out = q[k].alu;
      alu_zero = q[k].zero;
      #1;
      g = sample(q[k].e);
      chk($sformatf("cycle%0d_st%0d", k, q[k].e.st), 256'(g), 256'(q[k].e));
`ifdef CTRL_PERF_EN
      chk("cycle_cnt", 256'(cycle_cnt), 256'(mcyc));
      chk("instret", 256'(instret), 256'(minst));
`endif
      mcyc++;
      if (g.rfwe) begin
        seen = 1'b1;
        rdv = g.rd;
      end
    end
    if (stop_at < 0) minst++;
    mpc = npc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc", 256'(pc), 256'(RESET_PC));
    chk("rst_state", 256'(state), 256'(0));
    chk("rst_req", 256'(bus.req), 256'(0));
    chk("rst_rfwe", 256'(rf_we), 256'(0));
    chk("rst_ir", 256'(ir), 256'(0));
`ifdef CTRL_PERF_EN
    chk("rst_instret", 256'(instret), 256'(0));
    chk("rst_cycle", 256'(cycle_cnt), 256'(0));
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_state", 256'(state), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_state", 256'(state), 256'(0));
    chk("boot_req", 256'(bus.req), 256'(0));
    @(posedge clk);
    #1;
    chk("fetch_state", 256'(state), 256'(1));
    chk("fetch_req", 256'(bus.req), 256'(1));
    chk("fetch_addr", 256'(bus.addr), 256'(RESET_PC));
    mpc = RESET_PC;
    mir = '0;
    malu = '0;
    mmdr = '0;
    mcyc = '0;
    minst = '0;
  endtask

  task automatic rand_instr();
    vec_t v;
    logic seen;
    logic [31:0] rdv;
    v = mk(5'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 3), '0, 1'b0, '0);
    run_instr(v, -1, seen, rdv);
  endtask

  initial begin
    logic seen;
    logic [31:0] rdv;
    vec_t v;
    reset = 1'b1;
    {dec_branch, dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg} = '0;
    imm = '0;
    rs2_data = '0;
    alu_out = '0;
    alu_zero = 1'b0;
    bus.ready = 1'b0;
    bus.rdata = '0;
    tbl[0]  = mk(5'b00010, 32'h00500093, 32'h5,        32'h0,        32'h0,        32'h0,        1'b0, 0, 0, 32'h4,        1'b1, 32'h5);
    tbl[1]  = mk(5'b01011, 32'h10002083, 32'h100,      32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 0, 3, 32'h8,        1'b1, 32'hDEADBEEF);
    tbl[2]  = mk(5'b10000, 32'h00000463, 32'h0,        32'h8,        32'h0,        32'h0,        1'b1, 0, 0, 32'h10,       1'b0, 32'h0);
    tbl[3]  = mk(5'b10000, 32'hFE000CE3, 32'h0,        32'hFFFFFFF8, 32'h0,        32'h0,        1'b1, 0, 0, 32'h8,        1'b0, 32'h0);
    tbl[4]  = mk(5'b10000, 32'h00000463, 32'h0,        32'h8,        32'h0,        32'h0,        1'b1, 0, 0, 32'h10,       1'b0, 32'h0);
    tbl[5]  = mk(5'b10000, 32'hFE000CE3, 32'h1,        32'hFFFFFFF8, 32'h0,        32'h0,        1'b0, 0, 0, 32'h14,       1'b0, 32'h0);
    tbl[6]  = mk(5'b00100, 32'h04202023, 32'h40,       32'h0,        32'h12345678, 32'h0,        1'b0, 0, 0, 32'h18,       1'b0, 32'h0);
    tbl[7]  = mk(5'b01110, 32'h04402223, 32'h44,       32'h0,        32'hCAFEF00D, 32'h11111111, 1'b0, 0, 1, 32'h1C,       1'b0, 32'h0);
    tbl[8]  = mk(5'b11111, 32'h10000063, 32'h0,        32'h100,      32'h0,        32'h0,        1'b0, 0, 0, 32'h20,       1'b0, 32'h0);
    tbl[9]  = mk(5'b01001, 32'h08002003, 32'h80,       32'h0,        32'h0,        32'h55,       1'b0, 0, 2, 32'h24,       1'b0, 32'h0);
    tbl[10] = mk(5'b00000, 32'h00000013, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 2, 0, 32'h28,       1'b0, 32'h0);
    tbl[11] = mk(5'b00010, 32'h00A00113, 32'hABCD,     32'h0,        32'h0,        32'h0,        1'b0, 1, 0, 32'h2C,       1'b1, 32'hABCD);
    tbl[12] = mk(5'b10000, 32'hFC000063, 32'h0,        32'hFFFFFFD3, 32'h0,        32'h0,        1'b1, 0, 0, 32'hFFFFFFFF, 1'b0, 32'h0);
    tbl[13] = mk(5'b00000, 32'h00000013, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 0, 0, 32'h3,        1'b0, 32'h0);
    tbl[14] = mk(5'b00011, 32'h00300193, 32'h9,        32'h0,        32'h0,        32'h0,        1'b0, 0, 0, 32'h7,        1'b1, 32'h55);
    #2;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i], -1, seen, rdv);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i), 256'(pc), 256'(tbl[i].epc));
      chk($sformatf("vec%0d_rfwe", i), 256'(seen), 256'(tbl[i].erf));
      chk($sformatf("vec%0d_rd", i), 256'(rdv), 256'(tbl[i].erd));
    end
    for (int i = 0; i < 200; i++) rand_instr();
    // abort a load stalled in MEM: FETCH, DECODE, EXEC, then two MEM wait cycles
    v = mk(5'b01011, 32'h00002083, 32'h200, 32'h0, 32'h0, 32'h77, 1'b0, 0, 6, 32'h0, 1'b0, 32'h0);
    run_instr(v, 5, seen, rdv);
    do_reset();
    for (int i = 0; i < 20; i++) rand_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
